// File: rtl/popcount_arbiter_pkg.sv
// Shared state encodings and width-derivation helpers for the popcount arbiter.
package popcount_arbiter_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    function automatic int cw_of(input int dw);
        return $clog2(dw + 1);
    endfunction

    function automatic int idw_of(input int nreq);
        return $clog2(nreq);
    endfunction

endpackage

// File: rtl/popcount_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  win_id,
    output logic [NREQ-1:0] onehot
);

    always_comb begin
        int idx;
        idx    = 0;
        any    = 1'b0;
        win_id = '0;
        onehot = '0;
        // Scan from the farthest offset down so the nearest request to ptr overwrites last.
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                any         = 1'b1;
                win_id      = idx[IDW-1:0];
                onehot      = '0;
                onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/popcount_arbiter.sv
// Round-robin scheduler sharing a single popcount unit among NREQ requesters.
module popcount_arbiter
    import popcount_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 7,
    parameter int CW   = cw_of(DW),
    parameter int IDW  = idw_of(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*DW-1:0] data,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic             done,
    output logic [IDW-1:0]   done_id,
    output logic [CW-1:0]    count
);

    function automatic logic [CW-1:0] popcount(input logic [DW-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DW; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            done_q, done_d;
    logic [IDW-1:0]  done_id_q, done_id_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  w_q, w_d;
    logic [DW-1:0]   op_q, op_d;

    logic            pick_any;
    logic [IDW-1:0]  pick_id;
    logic [NREQ-1:0] pick_oh;
    logic [CW-1:0]   pop_cnt;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .win_id (pick_id),
        .onehot (pick_oh)
    );

    // The one shared counting unit; only the latched operand ever reaches it.
    assign pop_cnt = popcount(op_q);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = done_q;
        done_id_d = done_id_q;
        count_d   = count_q;
        ptr_d     = ptr_q;
        w_d       = w_q;
        op_d      = op_q;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    op_d    = data[int'(pick_id)*DW +: DW];
                    gnt_d   = pick_oh;
                    w_d     = pick_id;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                count_d   = pop_cnt;
                done_id_d = w_q;
                done_d    = 1'b1;
                state_d   = S_RESP;
            end
            S_RESP: begin
                gnt_d   = '0;
                done_d  = 1'b0;
                ptr_d   = (w_q == IDW'(NREQ - 1)) ? '0 : w_q + IDW'(1);
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            count_q   <= '0;
            ptr_q     <= '0;
            w_q       <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            count_q   <= count_d;
            ptr_q     <= ptr_d;
            w_q       <= w_d;
        end
    end

    // Operand is pure data; it is only consumed after being loaded in IDLE.
    always_ff @(posedge clk) begin
        op_q <= op_d;
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign done_id = done_id_q;
    assign count   = count_q;

endmodule
